// File: rtl/gaussian_hls_pkg.sv
// Shared types and default widths for the Gaussian blur tap accumulation stage.
// Defaults match the kernel-weight multiplier instances feeding and fed by this block.
package gaussian_hls_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int IN_W_DEF  = 21;
  localparam int OUT_W_DEF = 13;
  localparam int SHIFT_DEF = 8;
  localparam int TAPS_DEF  = 9;

  function automatic int acc_width(input int in_w, input int taps);
    return in_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/gaussian_round_sat.sv
// Round-half-up normalisation by 2^SHIFT, then saturation to OUT_W bits.
// Purely combinational: zero latency, no handshake.
module gaussian_round_sat #(
  parameter int ACC_W = 25,
  parameter int SHIFT = 8,
  parameter int OUT_W = 13
) (
  input  logic [ACC_W-1:0] sum,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam logic [ACC_W:0] RND  = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic [ACC_W:0] MAXV = (ACC_W+1)'({OUT_W{1'b1}});

  // One extra bit so the rounding add cannot wrap.
  logic [ACC_W:0] r;

  always_comb begin
    r        = ({1'b0, sum} + RND) >> SHIFT;
    out_sat  = (r > MAXV);
    out_data = out_sat ? {OUT_W{1'b1}} : r[OUT_W-1:0];
  end

endmodule

// File: rtl/gaussian_tap_accumulator.sv
// Sums TAPS products per window, emits one rounded/saturated pixel 1 cycle after the last tap.
// Output holds until out_ready; input stalls only while a pixel waits and out_ready is low.
module gaussian_tap_accumulator
  import gaussian_hls_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int TAPS  = TAPS_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic            ap_clk,
  input  logic            ap_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic            out_sat,
  output logic            err_last
);

  localparam int ACC_W = acc_width(IN_W, TAPS);
  localparam int CNT_W = $clog2(TAPS);

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   tap_cnt, cnt_nxt;
  logic [OUT_W-1:0]   dat_nxt;
  logic               sat_nxt, err_nxt;

  logic               accept;
  logic               last_tap;
  logic [ACC_W-1:0]   sum;
  logic [OUT_W-1:0]   rs_data;
  logic               rs_sat;

  assign in_ready  = (state == ACCUM) || out_ready;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_tap  = (tap_cnt == CNT_W'(TAPS - 1));
  assign sum       = acc + ACC_W'(in_data);

  gaussian_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .sum      (sum),
    .out_data (rs_data),
    .out_sat  (rs_sat)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = tap_cnt;
    dat_nxt   = out_data;
    sat_nxt   = out_sat;
    // in_last is only cross-checked; the counter alone delimits windows.
    err_nxt   = err_last || (accept && (in_last != last_tap));
    case (state)
      ACCUM: begin
        if (accept) begin
          if (last_tap) begin
            dat_nxt   = rs_data;
            sat_nxt   = rs_sat;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            acc_nxt = sum;
            cnt_nxt = tap_cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = ACCUM;
          // A beat arriving as the pixel retires opens the next window.
          if (in_valid) begin
            acc_nxt = ACC_W'(in_data);
            cnt_nxt = CNT_W'(1);
          end
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= ACCUM;
      acc      <= '0;
      tap_cnt  <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
      err_last <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      tap_cnt  <= cnt_nxt;
      out_data <= dat_nxt;
      out_sat  <= sat_nxt;
      err_last <= err_nxt;
    end
  end

endmodule
